// File: rtl/seg_break_if.sv
// Packet-FIFO read side and output-FIFO write side of the packet segmenter.
// master = the segmenter; slave = the FIFOs (or bench) around it.
// Clock and reset stay plain ports on the modules that use this bundle.
interface seg_break_if #(
  parameter int BYTES = 8,
  parameter int LEN_W = 13
);
  logic [BYTES*8-1:0] pkt_fifo_rd_data;
  logic [LEN_W-1:0]   pkt_fifo_len;
  logic               pkt_fifo_ne;
  logic               pkt_fifo_re;
  logic [BYTES*8-1:0] out_fifo_wr_data;
  logic [BYTES-1:0]   out_fifo_wr_be;
  logic               out_fifo_wr_sop;
  logic               out_fifo_wr_eop;
  logic               out_fifo_wr_last;
  logic               out_fifo_we;
  logic               out_fifo_full;

  modport master (
    input  pkt_fifo_rd_data, pkt_fifo_len, pkt_fifo_ne, out_fifo_full,
    output pkt_fifo_re, out_fifo_wr_data, out_fifo_wr_be, out_fifo_wr_sop,
           out_fifo_wr_eop, out_fifo_wr_last, out_fifo_we
  );

  modport slave (
    output pkt_fifo_rd_data, pkt_fifo_len, pkt_fifo_ne, out_fifo_full,
    input  pkt_fifo_re, out_fifo_wr_data, out_fifo_wr_be, out_fifo_wr_sop,
           out_fifo_wr_eop, out_fifo_wr_last, out_fifo_we
  );
endinterface

// File: rtl/seg_break.sv
// Splits word-aligned packets from a FIFO into byte-enabled segments (fixed or LFSR lengths).
// Latency: a word staged in cycle N is written in N+2; its packet-FIFO pop pulses in N+1.
// Backpressure: no staging while the packet FIFO is empty or the output FIFO is full; 2 words may still land.
module seg_break #(
  parameter int          BYTES     = 8,
  parameter int          LEN_W     = 13,
  parameter logic [11:0] LFSR_SEED = 12'h001,
  parameter logic [7:0]  FILL      = 8'hff
) (
  input  logic        clk,
  input  logic        reset_l,
  seg_break_if.master bus,
  input  logic        seg_mode,
  input  logic [11:0] seg_fixed_len,
  output logic        busy,
  output logic [15:0] seg_cnt
);
  localparam int               LSB      = $clog2(BYTES);
  localparam int               W        = BYTES * 8;
  localparam logic [LSB-1:0]   LANE_MAX = LSB'(BYTES - 1);
  localparam logic [BYTES-1:0] ONES     = '1;

  typedef enum logic [2:0] {IDLE, NEXT_SEG, MASKS, FIRST, REST} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] count, count_nxt, offset, offset_nxt;
  logic [LEN_W-1:0] seg_len, seg_len_nxt, last_off, last_off_nxt;
  logic [LEN_W-1:0] word_cnt, word_cnt_nxt;
  logic [BYTES-1:0] first_mask, first_mask_nxt, last_mask, last_mask_nxt;
  logic [11:0]      lfsr, lfsr_nxt;
  logic [15:0]      seg_cnt_nxt;
  logic [LEN_W-1:0] len_pick, len_seg;
  logic             last_word, pkt_end, advance;

  // Word staged this cycle (stage 0 combinational view)
  logic             stg_vld, stg_sop, stg_eop, stg_last, stg_pop;
  logic [BYTES-1:0] stg_be;
  // Stage 1 registers
  logic             s1_vld, s1_sop, s1_eop, s1_last, s1_pop;
  logic [BYTES-1:0] s1_be;
  logic [W-1:0]     s1_dat, fill_dat;

  assign busy            = (state != IDLE);
  assign bus.pkt_fifo_re = s1_pop;
  assign advance         = bus.pkt_fifo_ne && !bus.out_fifo_full;
  assign last_word       = (word_cnt == LEN_W'(1));
  assign pkt_end         = last_word && (seg_len == count);

  // Candidate segment length for NEXT_SEG, clipped to what is left of the packet.
  always_comb begin
    if (!seg_mode)                   len_pick = LEN_W'(lfsr);
    else if (seg_fixed_len == 12'd0) len_pick = count;
    else                             len_pick = LEN_W'(seg_fixed_len);
    len_seg = (len_pick < count) ? len_pick : count;
  end

  // Next-state, segment bookkeeping and the word to stage this cycle.
  always_comb begin
    state_nxt      = state;
    count_nxt      = count;
    offset_nxt     = offset;
    seg_len_nxt    = seg_len;
    last_off_nxt   = last_off;
    word_cnt_nxt   = word_cnt;
    first_mask_nxt = first_mask;
    last_mask_nxt  = last_mask;
    lfsr_nxt       = lfsr;
    seg_cnt_nxt    = seg_cnt;
    stg_vld        = 1'b0;
    stg_sop        = 1'b0;
    stg_eop        = 1'b0;
    stg_last       = 1'b0;
    stg_pop        = 1'b0;
    stg_be         = '0;
    case (state)
      IDLE: begin
        if (bus.pkt_fifo_ne) begin
          if (bus.pkt_fifo_len == '0) begin
            // Empty packet still occupies one FIFO word: drop it.
            stg_pop = 1'b1;
          end else begin
            count_nxt  = bus.pkt_fifo_len;
            offset_nxt = '0;
            state_nxt  = NEXT_SEG;
          end
        end
      end
      NEXT_SEG: begin
        if (count == '0) begin
          state_nxt = IDLE;
        end else begin
          seg_len_nxt  = len_seg;
          last_off_nxt = offset + len_seg - LEN_W'(1);
          if (!seg_mode) lfsr_nxt = {lfsr[10:0], lfsr[11] ^ lfsr[10] ^ lfsr[9] ^ lfsr[3]};
          state_nxt = MASKS;
        end
      end
      MASKS: begin
        first_mask_nxt = ONES << offset[LSB-1:0];
        last_mask_nxt  = ONES >> (LANE_MAX - last_off[LSB-1:0]);
        word_cnt_nxt   = LEN_W'(last_off[LEN_W-1:LSB] - offset[LEN_W-1:LSB]) + LEN_W'(1);
        state_nxt      = FIRST;
      end
      FIRST, REST: begin
        if (advance) begin
          stg_vld = 1'b1;
          stg_sop = (state == FIRST);
          if (state == FIRST) stg_be = last_word ? (first_mask & last_mask) : first_mask;
          else                stg_be = last_word ? last_mask : ONES;
          stg_eop      = last_word;
          stg_last     = pkt_end;
          // Pop when the word's top lane is consumed, or the packet ends (partial tail discarded).
          stg_pop      = stg_be[BYTES-1] | pkt_end;
          word_cnt_nxt = word_cnt - LEN_W'(1);
          if (last_word) begin
            offset_nxt  = offset + seg_len;
            count_nxt   = count - seg_len;
            seg_cnt_nxt = seg_cnt + 16'd1;
            state_nxt   = NEXT_SEG;
          end else begin
            state_nxt = REST;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state <= IDLE;
    else          state <= state_nxt;
  end

  // Segment bookkeeping registers and LFSR.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      count      <= '0;
      offset     <= '0;
      seg_len    <= '0;
      last_off   <= '0;
      word_cnt   <= '0;
      first_mask <= '0;
      last_mask  <= '0;
      lfsr       <= LFSR_SEED;
      seg_cnt    <= '0;
    end else begin
      count      <= count_nxt;
      offset     <= offset_nxt;
      seg_len    <= seg_len_nxt;
      last_off   <= last_off_nxt;
      word_cnt   <= word_cnt_nxt;
      first_mask <= first_mask_nxt;
      last_mask  <= last_mask_nxt;
      lfsr       <= lfsr_nxt;
      seg_cnt    <= seg_cnt_nxt;
    end
  end

  // Stage 1: capture the staged word and markers; the pop strobe leaves from here.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      s1_vld  <= 1'b0;
      s1_sop  <= 1'b0;
      s1_eop  <= 1'b0;
      s1_last <= 1'b0;
      s1_pop  <= 1'b0;
      s1_be   <= '0;
      s1_dat  <= '0;
    end else begin
      s1_vld  <= stg_vld;
      s1_sop  <= stg_sop;
      s1_eop  <= stg_eop;
      s1_last <= stg_last;
      s1_pop  <= stg_pop;
      s1_be   <= stg_be;
      if (stg_vld) s1_dat <= bus.pkt_fifo_rd_data;
    end
  end

  // Disabled byte lanes are replaced by FILL on the way into stage 2.
  always_comb begin
    for (int i = 0; i < BYTES; i++) begin
      fill_dat[i*8 +: 8] = s1_be[i] ? s1_dat[i*8 +: 8] : FILL;
    end
  end

  // Stage 2: output FIFO write port.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      bus.out_fifo_we      <= 1'b0;
      bus.out_fifo_wr_data <= '0;
      bus.out_fifo_wr_be   <= '0;
      bus.out_fifo_wr_sop  <= 1'b0;
      bus.out_fifo_wr_eop  <= 1'b0;
      bus.out_fifo_wr_last <= 1'b0;
    end else begin
      bus.out_fifo_we      <= s1_vld;
      bus.out_fifo_wr_data <= fill_dat;
      bus.out_fifo_wr_be   <= s1_be;
      bus.out_fifo_wr_sop  <= s1_sop;
      bus.out_fifo_wr_eop  <= s1_eop;
      bus.out_fifo_wr_last <= s1_last;
    end
  end
endmodule

// File: tb/tb_seg_break.sv
// Bench for seg_break: byte-level segment model, show-ahead packet FIFO, randomized traffic.
// Every output write is compared against the model queue, including the pop that preceded it.
// Directed cases pin the model with hand-computed values.
module tb_seg_break;
  localparam int         BYTES = 8;
  localparam int         LEN_W = 13;
  localparam int         W     = BYTES * 8;
  localparam int         DEPTH = 4096;
  localparam logic [7:0] FILL  = 8'hff;

  typedef struct packed {
    logic [W-1:0]     dat;
    logic [BYTES-1:0] be;
    logic             sop;
    logic             eop;
    logic             last;
    logic             pop;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic        seg_mode = 1'b1;
  logic [11:0] seg_fixed_len = 12'd0;
  logic        busy;
  logic [15:0] seg_cnt;

  seg_break_if #(.BYTES(BYTES), .LEN_W(LEN_W)) bus ();

  seg_break #(.BYTES(BYTES), .LEN_W(LEN_W), .LFSR_SEED(12'h001), .FILL(FILL)) dut (
    .clk(clk), .reset_l(reset_l), .bus(bus), .seg_mode(seg_mode),
    .seg_fixed_len(seg_fixed_len), .busy(busy), .seg_cnt(seg_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  // ---------------- show-ahead packet FIFO ----------------
  logic [W-1:0]     mem_dat [DEPTH];
  logic [LEN_W-1:0] mem_len [DEPTH];
  int   wr_cnt = 0;
  int   rd_ptr = 0;
  int   pop_cnt = 0;
  int   head;
  logic ne_gate = 1'b1;

  always_comb begin
    head                 = rd_ptr + (bus.pkt_fifo_re ? 1 : 0);
    bus.pkt_fifo_ne      = ne_gate && (head < wr_cnt);
    bus.pkt_fifo_rd_data = mem_dat[head % DEPTH];
    bus.pkt_fifo_len     = mem_len[head % DEPTH];
  end

  always @(posedge clk) begin
    if (bus.pkt_fifo_re) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  // ---------------- flow-control stimulus ----------------
  int full_mode = 0;
  bit gate_mode = 1'b0;

  initial begin
    bus.out_fifo_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (full_mode)
        0:       bus.out_fifo_full = 1'b0;
        1:       bus.out_fifo_full = !bus.out_fifo_full;
        default: bus.out_fifo_full = ($urandom_range(0, 2) == 0);
      endcase
      ne_gate = gate_mode ? ($urandom_range(0, 4) != 0) : 1'b1;
    end
  end

  // ---------------- behavioural model ----------------
  ent_t        expq[$];
  ent_t        mlog[$];
  int          seglog[$];
  logic [11:0] m_lfsr = 12'h001;

  function automatic logic [11:0] lfsr_next(input logic [11:0] v);
    return {v[10:0], v[11] ^ v[10] ^ v[9] ^ v[3]};
  endfunction

  // Walk the packet byte by byte: each segment covers bytes [off, off+sl) in packet order.
  task automatic model_pkt(input int base, input int len);
    int   cnt, off, l, sl, fw, lw, idx;
    ent_t e;
    cnt = len;
    off = 0;
    while (cnt > 0) begin
      if (!seg_mode) begin
        l = int'(m_lfsr);
        m_lfsr = lfsr_next(m_lfsr);
      end else if (seg_fixed_len == 12'd0) begin
        l = cnt;
      end else begin
        l = int'(seg_fixed_len);
      end
      sl = (l < cnt) ? l : cnt;
      seglog.push_back(sl);
      fw = off / BYTES;
      lw = (off + sl - 1) / BYTES;
      for (int w = fw; w <= lw; w++) begin
        for (int b = 0; b < BYTES; b++) begin
          idx = w * BYTES + b;
          e.be[b] = (idx >= off) && (idx < off + sl);
          e.dat[b*8 +: 8] = e.be[b] ? mem_dat[(base + w) % DEPTH][b*8 +: 8] : FILL;
        end
        e.sop  = (w == fw);
        e.eop  = (w == lw);
        e.last = (w == lw) && (sl == cnt);
        e.pop  = e.be[BYTES-1] || e.last;
        expq.push_back(e);
        mlog.push_back(e);
      end
      off += sl;
      cnt -= sl;
    end
  endtask

  int sc_words = 0;

  task automatic push_pkt(input int len);
    int nw, base;
    logic [W-1:0] d;
    nw   = (len == 0) ? 1 : (len + BYTES - 1) / BYTES;
    base = wr_cnt;
    for (int w = 0; w < nw; w++) begin
      for (int b = 0; b < BYTES; b++) d[b*8 +: 8] = 8'($urandom);
      mem_dat[(base + w) % DEPTH] = d;
      mem_len[(base + w) % DEPTH] = (w == 0) ? LEN_W'(len) : '0;
    end
    model_pkt(base, len);
    sc_words += nw;
    wr_cnt = base + nw;
  endtask

  // ---------------- compare process ----------------
  logic re_d1 = 1'b0, full_d1 = 1'b0, full_d2 = 1'b0;
  int   wcnt = 0;

  always @(negedge clk) begin
    ent_t got, e;
    if (reset_l) begin
      if (bus.out_fifo_we) begin
        wcnt++;
        got.dat  = bus.out_fifo_wr_data;
        got.be   = bus.out_fifo_wr_be;
        got.sop  = bus.out_fifo_wr_sop;
        got.eop  = bus.out_fifo_wr_eop;
        got.last = bus.out_fifo_wr_last;
        got.pop  = re_d1;
        if (expq.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL extra_word: got write be=%h, required no write", got.be);
        end else begin
          e = expq.pop_front();
          chk("word{dat,be,sop,eop,last,pop}", 96'(got), 96'(e));
        end
        chk("write_while_full", 96'(full_d2), 96'(0));
      end
      full_d2 = full_d1;
      full_d1 = bus.out_fifo_full;
      re_d1   = bus.pkt_fifo_re;
    end else begin
      full_d1 = 1'b0;
      full_d2 = 1'b0;
      re_d1   = 1'b0;
    end
  end

  // ---------------- scenario helpers ----------------
  int          sc_pop0 = 0;
  int          sc_w0 = 0;
  logic [15:0] sc_seg0 = 16'd0;

  task automatic begin_scn(input bit mode, input int fixed, input int fm, input bit gm);
    seg_mode      = mode;
    seg_fixed_len = 12'(fixed);
    full_mode     = fm;
    gate_mode     = gm;
    mlog.delete();
    seglog.delete();
    sc_words = 0;
    sc_pop0  = pop_cnt;
    sc_w0    = wcnt;
    sc_seg0  = seg_cnt;
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while (!(rd_ptr == wr_cnt && !busy && expq.size() == 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_total++;
    if (t >= 3000) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d words outstanding, required 0", nm, expq.size());
    end
    repeat (4) @(negedge clk);
    chk({nm, "_pops"}, 96'(pop_cnt - sc_pop0), 96'(sc_words));
    chk({nm, "_segs"}, 96'(16'(seg_cnt - sc_seg0)), 96'(16'(seglog.size())));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] v;
    int          t, np;

    #12;
    chk("reset_ctl{re,we,sop,eop,last,busy}",
        96'({bus.pkt_fifo_re, bus.out_fifo_we, bus.out_fifo_wr_sop, bus.out_fifo_wr_eop,
             bus.out_fifo_wr_last, busy}), 96'(0));
    chk("reset_data", 96'(bus.out_fifo_wr_data), 96'(0));
    chk("reset_be_segcnt", 96'({bus.out_fifo_wr_be, seg_cnt}), 96'(0));
    @(negedge clk);
    reset_l = 1'b1;

    // Fixed 8, len 16: two one-word segments.
    begin_scn(1'b1, 8, 0, 1'b0);
    push_pkt(16);
    chk("s1_model_words", 96'(mlog.size()), 96'(2));
    if (mlog.size() == 2) begin
      chk("s1_model_be", 96'({mlog[0].be, mlog[1].be}), 96'(16'hFFFF));
      chk("s1_model_marks", 96'({mlog[0].sop, mlog[0].eop, mlog[0].last, mlog[0].pop,
                                 mlog[1].sop, mlog[1].eop, mlog[1].last, mlog[1].pop}),
          96'(8'b1101_1111));
    end
    wait_done("s1");
    chk("s1_seg_cnt", 96'(seg_cnt), 96'(2));
    chk("s1_pops", 96'(pop_cnt - sc_pop0), 96'(2));

    // Fixed 5, len 16: be 1F | E0,03 | 7C | 80.
    begin_scn(1'b1, 5, 0, 1'b0);
    push_pkt(16);
    chk("s2_model_words", 96'(mlog.size()), 96'(5));
    if (mlog.size() == 5) begin
      v = '0;
      for (int i = 0; i < 5; i++) v = {v[55:0], mlog[i].be};
      chk("s2_model_be", 96'(v), 96'(64'h1FE0037C80));
      v = '0;
      for (int i = 0; i < 5; i++) v = {v[59:0], mlog[i].sop, mlog[i].eop, mlog[i].last, mlog[i].pop};
      chk("s2_model_marks", 96'(v), 96'(20'b1100_1001_0100_1100_1111));
      chk("s2_model_fill", 96'(mlog[0].dat[63:40]), 96'(24'hFFFFFF));
    end
    wait_done("s2");
    chk("s2_pops", 96'(pop_cnt - sc_pop0), 96'(2));
    chk("s2_segs", 96'(16'(seg_cnt - sc_seg0)), 96'(4));

    // Random mode from seed 1, len 64: 1,2,4,8,17 then 32.
    begin_scn(1'b0, 0, 0, 1'b0);
    push_pkt(64);
    chk("s3_model_nseg", 96'(seglog.size()), 96'(6));
    if (seglog.size() == 6) begin
      v = '0;
      for (int i = 0; i < 6; i++) v = {v[55:0], 8'(seglog[i])};
      chk("s3_model_lens", 96'(v), 96'(48'h01_02_04_08_11_20));
    end
    wait_done("s3");
    chk("s3_pops", 96'(pop_cnt - sc_pop0), 96'(8));
    chk("s3_segs", 96'(16'(seg_cnt - sc_seg0)), 96'(6));

    // Whole-packet segments: len 13 then len 8 starting word-aligned.
    begin_scn(1'b1, 0, 0, 1'b0);
    push_pkt(13);
    push_pkt(8);
    chk("s4_model_words", 96'(mlog.size()), 96'(3));
    if (mlog.size() == 3) begin
      chk("s4_model_be", 96'({mlog[0].be, mlog[1].be, mlog[2].be}), 96'(24'hFF1FFF));
      chk("s4_model_pop", 96'({mlog[0].pop, mlog[1].pop, mlog[2].pop}), 96'(3'b111));
    end
    wait_done("s4");
    chk("s4_pops", 96'(pop_cnt - sc_pop0), 96'(3));

    // out_fifo_full toggling every cycle mid-segment.
    begin_scn(1'b1, 3, 1, 1'b0);
    push_pkt(40);
    push_pkt(23);
    wait_done("s5");
    begin_scn(1'b0, 0, 1, 1'b1);
    push_pkt(50);
    wait_done("s5r");

    // Randomized traffic: mode, segment length, packet lengths, full and empty stalls.
    for (int s = 0; s < 20; s++) begin
      begin_scn(1'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0) ? $urandom_range(100, 300) : $urandom_range(0, 20),
                2, 1'($urandom_range(0, 1)));
      np = $urandom_range(1, 6);
      for (int p = 0; p < np; p++) push_pkt($urandom_range(0, 100));
      wait_done("rand");
    end

    // Reset in the middle of a multi-word segment.
    begin_scn(1'b1, 0, 0, 1'b0);
    push_pkt(200);
    t = 0;
    while (!(bus.out_fifo_we && !bus.out_fifo_wr_sop) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("rst_reach_rest", 96'(t >= 500), 96'(0));
    #1;
    reset_l = 1'b0;
    expq.delete();
    #1;
    chk("rst_ctl{re,we,sop,eop,last,busy}",
        96'({bus.pkt_fifo_re, bus.out_fifo_we, bus.out_fifo_wr_sop, bus.out_fifo_wr_eop,
             bus.out_fifo_wr_last, busy}), 96'(0));
    chk("rst_data_be", 96'({bus.out_fifo_wr_data, bus.out_fifo_wr_be}), 96'(0));
    chk("rst_seg_cnt", 96'(seg_cnt), 96'(0));
    @(negedge clk);
    @(negedge clk);
    reset_l = 1'b1;
    m_lfsr  = 12'h001;
    wr_cnt  = rd_ptr;
    begin_scn(1'b1, 8, 0, 1'b0);
    push_pkt(0);
    repeat (10) @(negedge clk);
    chk("rst_len0_pops", 96'(pop_cnt - sc_pop0), 96'(1));
    chk("rst_len0_writes", 96'(wcnt - sc_w0), 96'(0));
    chk("rst_len0_idle", 96'({busy, seg_cnt}), 96'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/seg_break.md
# seg_break

Parametrised packet segmenter for the unit-test traffic path. Pops word-aligned packets of arbitrary byte length from a packet FIFO and re-emits each packet as a sequence of byte-enabled segments, with fixed or pseudo-random segment lengths. Each output word carries start/end-of-segment and end-of-packet markers, which makes it a stress source for downstream reassembly and merge logic.

## Interface
- BYTES, 8, bytes per data word; power of two, 4..16
- LEN_W, 13, width of packet length and byte counters
- LFSR_SEED, 12'h001, nonzero reset value of segment LFSR
- FILL, 8'hff, value driven on disabled output byte lanes
- clk  in  1  clock
- reset_l  in  1  reset, asynchronous, active-low
- pkt_fifo_rd_data  in  BYTES*8  head word of packet FIFO; byte 0 = bits [7:0]
- pkt_fifo_len  in  LEN_W  byte length of packet at head; valid with first word
- pkt_fifo_ne  in  1  packet FIFO not empty
- pkt_fifo_re  out  1  pop head word
- seg_mode  in  1  0 = random length (LFSR), 1 = fixed length
- seg_fixed_len  in  12  fixed segment length in bytes; 0 = whole remaining packet
- out_fifo_wr_data  out  BYTES*8  output word, disabled lanes = FILL
- out_fifo_wr_be  out  BYTES  byte enables
- out_fifo_wr_sop  out  1  first word of segment
- out_fifo_wr_eop  out  1  last word of segment
- out_fifo_wr_last  out  1  word ends final segment of packet
- out_fifo_we  out  1  write strobe
- out_fifo_full  in  1  output FIFO full; must assert with ≥2 free entries
- busy  out  1  state != IDLE
- seg_cnt  out  16  segments emitted, wraps at 2^16

## Operation
- States: IDLE, NEXT_SEG, MASKS, FIRST, REST.
- IDLE, pkt_fifo_ne=1: latch count=pkt_fifo_len, offset=0 -> NEXT_SEG. If pkt_fifo_len==0: pulse pkt_fifo_re once, stay IDLE, emit nothing.
- NEXT_SEG, count==0: -> IDLE. Otherwise compute L: random mode L = LFSR value; fixed mode L = seg_fixed_len, or count if seg_fixed_len==0. seg_len = min(L, count). last_off = offset+seg_len-1. LFSR advances only in random mode: {v[10:0], v[11]^v[10]^v[9]^v[3]}. seg_mode and seg_fixed_len are sampled here only -> MASKS.
- MASKS: first_mask = ones<<offset[lsb]; last_mask = ones>>(BYTES-1-last_off[lsb]); word_count = last_off[hi]-offset[hi]+1. lsb = low log2(BYTES) bits; hi = the remaining bits -> FIRST.
- FIRST/REST advance only on cycles with pkt_fifo_ne && !out_fifo_full. Each such cycle stages one word with word_count decremented:
  - FIRST: sop=1. be = first_mask&last_mask if it is the last word, else first_mask.
  - REST: be = last_mask on the last word, else all ones.
  - eop=1 on the last word. last=1 on the last word when seg_len==count.
  - A non-final FIRST word -> REST.
  - The last word updates offset+=seg_len and count-=seg_len, seg_cnt++, -> NEXT_SEG.
- Pop rule: pkt_fifo_re pulses with a staged word iff its be[BYTES-1]=1 or it ends the packet. A partial final word is discarded so the next packet starts word-aligned.
- Widths: offset/count LEN_W; segment lengths zero-extended; LFSR never zero.
- Reset: all registers to reset values and LFSR to LFSR_SEED, at any state. Any partial packet is abandoned.

## Timing
- Output reset values: pkt_fifo_re=0, out_fifo_we=0, wr_data=0, be=0, sop=eop=last=0, busy=0, seg_cnt=0.
- Two-stage output pipeline: a word staged in cycle N appears with out_fifo_we=1 in cycle N+2. FILL substitution happens in stage 2.
- pkt_fifo_re is a single-cycle pulse in cycle N+1. pkt_fifo_rd_data must reflect the next word by the next advance cycle.
- Inter-segment gap: 2 idle cycles (NEXT_SEG, MASKS). Packet start: 1 IDLE cycle.
- Full throughput: one word/cycle within a segment while ne && !full.
- out_fifo_full asserted in cycle N: no staging in N. Up to 2 in-flight words still write.

## Test plan
- BYTES=8, fixed 8, len 16 -> 2 segments, each 1 word be=FF sop=eop=1; last on 2nd; 2 pops; seg_cnt=2.
- Fixed 5, len 16 -> be sequence 1F | E0,03 | 7C | 80.
  - Pops with the E0 word and the 80 word.
  - last only on the 80 word.
  - Disabled lanes read FF.
- Random mode, seed 1, len 64 -> segment lengths 1,2,4,8,17, then remainder 32 (min with count); 8 pops; seg_cnt=6.
- Len 13, fixed 0 -> one segment: FF then 1F; 2nd word pops despite be[7]=0; next packet starts at byte 0.
- out_fifo_full toggled every other cycle mid-segment -> no lost/duplicated words; ≤2 writes after full rises.
- Reset asserted mid-REST -> all outputs 0 immediately. After release, a fresh packet with len 0 gives 1 pop and no writes.
